// File: rtl/sequential_inverse_interp_pkg.sv
// Shared definitions for the inverse interpolator: FSM states, result
// classes and the all-ones frac helper also used by the forward interpolators.
package sequential_inverse_interp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_DIVIDE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_NORMAL   = 2'd0,
        CLS_CLAMP_LO = 2'd1,
        CLS_CLAMP_HI = 2'd2,
        CLS_DEGEN    = 2'd3
    } cls_t;

    // Saturated frac value (all ones) for a frac of the given width.
    function automatic logic [31:0] frac_all_ones(input int unsigned bits);
        if (bits >= 32'd32) begin
            return 32'hFFFF_FFFF;
        end else begin
            return (32'd1 << bits) - 32'd1;
        end
    endfunction

endpackage

// File: rtl/inv_interp_div_step.sv
// One restoring-division step: shift the remainder left, subtract the divisor
// when it fits, and report the resulting quotient bit.
module inv_interp_div_step #(
    parameter int W = 18
) (
    input  logic [W-1:0] r,
    input  logic [W-1:0] d,
    output logic [W-1:0] r_next,
    output logic         q_bit
);

    logic [W-1:0] r2_s;

    // Trial subtraction of the divisor from the doubled remainder.
    always_comb begin
        r2_s = r << 1;
        if (r2_s >= d) begin
            r_next = r2_s - d;
            q_bit  = 1'b1;
        end else begin
            r_next = r2_s;
            q_bit  = 1'b0;
        end
    end

endmodule

// File: rtl/sequential_inverse_interp.sv
// Multi-cycle inverse interpolator: finds frac such that interpolating
// base->target at frac lands at or just below value (toward base).
// Fixed latency: one SETUP cycle plus interp_bits DIVIDE cycles.
module sequential_inverse_interp
    import sequential_inverse_interp_pkg::*;
#(
    parameter int data_width  = 16,
    parameter int interp_bits = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   ready,
    input  logic [data_width-1:0]  base,
    input  logic [data_width-1:0]  target,
    input  logic [data_width-1:0]  value,
    output logic [interp_bits-1:0] frac,
    output logic                   done,
    output logic                   clamped,
    output logic                   degenerate
);

    localparam int DW = data_width;
    localparam int IB = interp_bits;
    localparam int RW = DW + 2;
    localparam int CW = (IB > 1) ? $clog2(IB) : 1;
    localparam logic [31:0]       ONES32 = frac_all_ones(IB);
    localparam logic signed [DW:0] ZERO_D = '0;

    state_t               state_r;
    state_t               next_state_s;
    cls_t                 cls_r;
    cls_t                 cls_s;
    logic signed [DW:0]   d_r;
    logic signed [DW:0]   o_r;
    logic signed [DW:0]   d_abs_s;
    logic signed [DW:0]   o_abs_s;
    logic [RW-1:0]        r_r;
    logic [RW-1:0]        r_next_s;
    logic [RW-1:0]        d_ext_s;
    logic                 q_bit_s;
    logic [CW-1:0]        cnt_r;
    logic [IB-1:0]        quot_r;
    logic [IB-1:0]        quot_next_s;
    logic                 accept_s;
    logic                 last_s;

    assign accept_s    = start & ready;
    assign last_s      = (state_r == ST_DIVIDE) && (cnt_r == {CW{1'b0}});
    assign d_ext_s     = {1'b0, d_r};
    assign quot_next_s = (quot_r << 1) | IB'(q_bit_s);

    inv_interp_div_step #(.W(RW)) u_div_step (
        .r      (r_r),
        .d      (d_ext_s),
        .r_next (r_next_s),
        .q_bit  (q_bit_s)
    );

    // Orient the segment upward and classify the pending result.
    always_comb begin
        d_abs_s = d_r;
        o_abs_s = o_r;
        cls_s   = CLS_NORMAL;
        if (d_r[DW]) begin
            d_abs_s = -d_r;
            o_abs_s = -o_r;
        end else begin
            d_abs_s = d_r;
            o_abs_s = o_r;
        end
        if (d_abs_s == ZERO_D) begin
            cls_s = CLS_DEGEN;
        end else if (o_abs_s <= ZERO_D) begin
            cls_s = CLS_CLAMP_LO;
        end else if (o_abs_s >= d_abs_s) begin
            cls_s = CLS_CLAMP_HI;
        end else begin
            cls_s = CLS_NORMAL;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: IDLE -> SETUP -> DIVIDE (interp_bits cycles) -> IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_SETUP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SETUP: next_state_s = ST_DIVIDE;
            ST_DIVIDE: begin
                if (cnt_r == {CW{1'b0}}) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DIVIDE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_r        <= '0;
            o_r        <= '0;
            r_r        <= '0;
            cnt_r      <= '0;
            quot_r     <= '0;
            cls_r      <= CLS_NORMAL;
            ready      <= 1'b1;
            frac       <= '0;
            done       <= 1'b0;
            clamped    <= 1'b0;
            degenerate <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        d_r   <= {target[DW-1], target} - {base[DW-1], base};
                        o_r   <= {value[DW-1], value} - {base[DW-1], base};
                        ready <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    d_r    <= d_abs_s;
                    r_r    <= {o_abs_s[DW], o_abs_s};
                    cls_r  <= cls_s;
                    cnt_r  <= CW'(IB - 1);
                    quot_r <= '0;
                end
                ST_DIVIDE: begin
                    r_r    <= r_next_s;
                    quot_r <= quot_next_s;
                    cnt_r  <= cnt_r - CW'(1);
                    if (last_s) begin
                        case (cls_r)
                            CLS_NORMAL:   frac <= quot_next_s;
                            CLS_CLAMP_HI: frac <= ONES32[IB-1:0];
                            CLS_CLAMP_LO: frac <= '0;
                            CLS_DEGEN:    frac <= '0;
                            default:      frac <= '0;
                        endcase
                        clamped    <= (cls_r == CLS_CLAMP_LO) || (cls_r == CLS_CLAMP_HI);
                        degenerate <= (cls_r == CLS_DEGEN);
                        done       <= 1'b1;
                        ready      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
